// File: rtl/shift_extractor.sv
// rtl/shift_extractor.sv - 3-stage pipelined 32-bit window extractor (right shift) from a 64-bit operand.
// Optional SHIFT_EXTRACTOR_STICKY_EN adds out_sticky (OR of bits shifted out below the window).
module shift_extractor #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*DATA_W-1:0]   in_b,
   input  logic [IDX_W-1:0]      shift_index,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_a
`ifdef SHIFT_EXTRACTOR_STICKY_EN
   ,
   output logic                  out_sticky
`endif
);

   localparam int IN_W = 2 * DATA_W;

   logic                advance;
   logic [IDX_W-1:0]    hi_amt;
   logic [IN_W-1:0]     s1_shifted;

   logic [IN_W-1:0]     s1_data_q,  s1_data_d;
   logic [3:0]          s1_lo_q,    s1_lo_d;
   logic                s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0]   s2_data_q,  s2_data_d;
   logic                s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0]   out_a_q,    out_a_d;
   logic                out_valid_q, out_valid_d;

   // One global stall: every stage moves together or not at all.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;
   assign hi_amt   = {shift_index[IDX_W-1:4], 4'b0000};
   assign s1_shifted = s1_data_q >> s1_lo_q;

   always_comb begin
      s1_data_d   = in_b >> hi_amt;
      s1_lo_d     = shift_index[3:0];
      s1_valid_d  = in_valid;
      s2_data_d   = s1_shifted[DATA_W-1:0];
      s2_valid_d  = s1_valid_q;
      out_a_d     = s2_data_q;
      out_valid_d = s2_valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data_q   <= '0;
         s1_lo_q     <= '0;
         s1_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_valid_q  <= 1'b0;
         out_a_q     <= '0;
         out_valid_q <= 1'b0;
      end else if (advance) begin
         s1_data_q   <= s1_data_d;
         s1_lo_q     <= s1_lo_d;
         s1_valid_q  <= s1_valid_d;
         s2_data_q   <= s2_data_d;
         s2_valid_q  <= s2_valid_d;
         out_a_q     <= out_a_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;

`ifdef SHIFT_EXTRACTOR_STICKY_EN
   localparam logic [IN_W-1:0] ONE = IN_W'(1);

   logic s1_sticky_q, s1_sticky_d;
   logic s2_sticky_q, s2_sticky_d;
   logic out_sticky_q, out_sticky_d;

   // Each stage ORs in the bits its own shift discards below bit 0.
   always_comb begin
      s1_sticky_d  = |(in_b & ((ONE << hi_amt) - ONE));
      s2_sticky_d  = s1_sticky_q | (|(s1_data_q & ((ONE << s1_lo_q) - ONE)));
      out_sticky_d = s2_sticky_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sticky_q  <= 1'b0;
         s2_sticky_q  <= 1'b0;
         out_sticky_q <= 1'b0;
      end else if (advance) begin
         s1_sticky_q  <= s1_sticky_d;
         s2_sticky_q  <= s2_sticky_d;
         out_sticky_q <= out_sticky_d;
      end
   end

   assign out_sticky = out_sticky_q;
`endif

endmodule

// File: tb/tb_shift_extractor.sv
// tb/tb_shift_extractor.sv - directed self-checking bench for shift_extractor.
// Define SHIFT_EXTRACTOR_STICKY_EN to also exercise out_sticky.
module tb_shift_extractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_b;
   logic [5:0]  shift_index;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
`ifdef SHIFT_EXTRACTOR_STICKY_EN
   logic        out_sticky;
`endif

   int total = 0;
   int bad   = 0;

   logic [63:0] vb [0:39];
   logic [5:0]  vi [0:39];
   logic [31:0] ve [0:39];

   always #5 clk = ~clk;

   shift_extractor #(.DATA_W(32), .IDX_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_b        (in_b),
      .shift_index (shift_index),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a)
`ifdef SHIFT_EXTRACTOR_STICKY_EN
      ,
      .out_sticky  (out_sticky)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

`ifdef SHIFT_EXTRACTOR_STICKY_EN
   function automatic logic sticky_of(input logic [63:0] b, input logic [5:0] idx);
      logic [63:0] one;
      one = 64'd1;
      return |(b & ((one << idx) - one));
   endfunction
`endif

   // Send one beat into an idle pipe and measure edges until out_valid.
   task automatic single_beat(input string tag, input logic [63:0] b, input logic [5:0] idx,
                              input logic [31:0] exp, input logic exp_sticky);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_b = b; shift_index = idx; out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd3);
      check({tag, "_out_a"}, 64'(out_a), 64'(exp));
`ifdef SHIFT_EXTRACTOR_STICKY_EN
      check({tag, "_sticky"}, 64'(out_sticky), 64'(exp_sticky));
`else
      if (exp_sticky) begin end
`endif
      @(negedge clk);
   endtask

   // Stream n beats from vb/vi, expect ve in order; out_ready held low for 'hold' cycles.
   task automatic run_stream(input string tag, input int n, input int hold,
                             output int cycles, output int stall_sent);
      int sent, got, cyc;
      logic acc;
      sent = 0; got = 0; cyc = 0; stall_sent = -1;
      while (got < n && cyc < 300) begin
         @(negedge clk);
         in_valid    = (sent < n);
         in_b        = vb[sent < n ? sent : 0];
         shift_index = vi[sent < n ? sent : 0];
         out_ready   = (cyc >= hold);
         #1;
         if (!in_ready && stall_sent < 0) stall_sent = sent;
         if (out_valid && !out_ready) check({tag, "_stall_hold"}, 64'(out_a), 64'(ve[got]));
         if (out_valid && out_ready) begin
            check({tag, "_data"}, 64'(out_a), 64'(ve[got]));
`ifdef SHIFT_EXTRACTOR_STICKY_EN
            check({tag, "_sticky"}, 64'(out_sticky), 64'(sticky_of(vb[got], vi[got])));
`endif
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) sent++;
         cyc++;
      end
      check({tag, "_count"}, 64'(got), 64'(n));
      @(negedge clk);
      in_valid = 1'b0;
      cycles = cyc;
   endtask

   initial begin
      int cycles, stall_sent, stale;
      rst = 1'b1; in_valid = 1'b0; in_b = '0; shift_index = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_a", 64'(out_a), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SHIFT_EXTRACTOR_STICKY_EN
      check("rst_sticky", 64'(out_sticky), 64'd0);
`endif

      single_beat("idx0",  64'h0000_0000_3AE5_1959, 6'd0,  32'h3AE5_1959, 1'b0);
      single_beat("idx32", 64'h3AE5_1959_0000_0000, 6'd32, 32'h3AE5_1959, 1'b0);
      single_beat("idx63", 64'h8000_0000_0000_0000, 6'd63, 32'h0000_0001, 1'b0);
      single_beat("idx40", 64'h0123_4567_89AB_CDEF, 6'd40, 32'h0001_2345, 1'b1);
      single_beat("sticky1", 64'h0000_0000_0000_0001, 6'd1, 32'h0000_0000, 1'b1);
      single_beat("sticky0", 64'h0000_0000_0000_0001, 6'd0, 32'h0000_0001, 1'b0);

      // Round trip through an expander: (x << k) >> k recovers x.
      for (int k = 0; k <= 32; k++) begin
         vb[k] = 64'h0000_0000_3AE5_1959 << k;
         vi[k] = 6'(k);
         ve[k] = 32'h3AE5_1959;
      end
      run_stream("roundtrip", 33, 0, cycles, stall_sent);
      check("roundtrip_cycles", 64'(cycles), 64'd36);

      vb[0] = 64'h0123_4567_89AB_CDEF; vi[0] = 6'd4;  ve[0] = 32'h789A_BCDE;
      vb[1] = 64'h0123_4567_89AB_CDEF; vi[1] = 6'd40; ve[1] = 32'h0001_2345;
      vb[2] = 64'h0123_4567_89AB_CDEF; vi[2] = 6'd20; ve[2] = 32'h3456_789A;
      vb[3] = 64'h0123_4567_89AB_CDEF; vi[3] = 6'd0;  ve[3] = 32'h89AB_CDEF;
      vb[4] = 64'h0123_4567_89AB_CDEF; vi[4] = 6'd63; ve[4] = 32'h0000_0000;
      run_stream("backpressure", 5, 6, cycles, stall_sent);
      check("backpressure_accepted", 64'(stall_sent), 64'd3);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_b = 64'hFFFF_FFFF_FFFF_FFFF; shift_index = 6'(i); out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_a", 64'(out_a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("midrst_no_stale", 64'(stale), 64'd0);
      single_beat("postrst", 64'h0000_0000_3AE5_1959, 6'd0, 32'h3AE5_1959, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
